// File: rtl/fetch_queue.sv
// Instruction-fetch stage: holds the PC, issues sequential reads to a
// 1-cycle-latency instruction memory and buffers the returned instructions
// (with their addresses) in a DEPTH-entry FIFO that decode drains with a
// valid/ready handshake. A redirect flushes everything and restarts fetch.
module fetch_queue #(
  parameter int              PC_W     = 13,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W-1:0]   occupancy;

  assign pop  = out_valid & out_ready;
  // A returning response is dropped when a redirect lands in the same cycle.
  assign push = inflight_q & ~redirect_valid;

  // Slots already claimed once this cycle's pop retires; a new request is
  // only allowed if its response is guaranteed a free slot next cycle.
  assign occupancy = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
  assign issue     = fetch_en & ~redirect_valid & rst & (occupancy < CNT_W'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign out_valid    = (count_q != '0);
  assign out_instr    = instr_mem_q[rd_ptr_q];
  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign out_pc_plus1 = out_pc + PC_W'(1);

  // Next PC and FIFO occupancy; redirect overrides everything else.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + PC_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: PC, request tracking, FIFO pointers and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) req_pc_q <= pc_q;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage: data only, no reset needed since out_valid guards it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // The issue throttle must never let a response arrive at a full FIFO.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst) push |-> (count_q != CNT_W'(DEPTH))
  );

endmodule
